// File: rtl/nibble_serial_alu_seq_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract sequencer.
package nibble_serial_alu_seq_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluAdc = 2'd1,
    AluSub = 2'd2,
    AluSbc = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } seq_state_t;

  // Subtraction is done as A + ~B + carry, so these ops invert B.
  function automatic logic op_is_sub(alu_op_t op);
    return (op == AluSub) || (op == AluSbc);
  endfunction

  // Carry (not-borrow) fed into nibble 0.
  function automatic logic op_init_carry(alu_op_t op, logic cin);
    logic c;
    unique case (op)
      AluAdd:  c = 1'b0;
      AluAdc:  c = cin;
      AluSub:  c = 1'b1;
      AluSbc:  c = cin;
      default: c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nibble_serial_alu_seq_if.sv
// Request/response bundle between execute control and the serial ALU.
interface nibble_serial_alu_seq_if
  import nibble_serial_alu_seq_pkg::*;
#(
  parameter int unsigned Width = 32
) ();

  logic             start;
  alu_op_t          op;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic             cin;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [Width-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op, a, b, cin, abort,
    input  ready, busy, done, result, carry_out, overflow, zero
  );

  modport slave (
    input  start, op, a, b, cin, abort,
    output ready, busy, done, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/nibble_serial_alu_seq_adder4.sv
// 4-bit carry-lookahead adder working from precomputed propagate/generate.
module nibble_serial_alu_seq_adder4 (
  input  logic [3:0] prop_i,
  input  logic [3:0] gen_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] c;

  // Flat lookahead equations, one level of logic per carry.
  always_comb begin
    c[0] = carry_i;
    c[1] = gen_i[0] | (prop_i[0] & carry_i);
    c[2] = gen_i[1] | (prop_i[1] & gen_i[0]) | (prop_i[1] & prop_i[0] & carry_i);
    c[3] = gen_i[2] | (prop_i[2] & gen_i[1]) | (prop_i[2] & prop_i[1] & gen_i[0]) |
           (prop_i[2] & prop_i[1] & prop_i[0] & carry_i);
    c[4] = gen_i[3] | (prop_i[3] & gen_i[2]) | (prop_i[3] & prop_i[2] & gen_i[1]) |
           (prop_i[3] & prop_i[2] & prop_i[1] & gen_i[0]) |
           (prop_i[3] & prop_i[2] & prop_i[1] & prop_i[0] & carry_i);
    sum_o   = prop_i ^ c[3:0];
    carry_o = c[4];
  end

endmodule

// File: rtl/nibble_serial_alu_seq.sv
// Multi-cycle add/subtract: one shared 4-bit adder steps across the operands LSB first.
// Width must be a multiple of 4 and at least 8.
module nibble_serial_alu_seq
  import nibble_serial_alu_seq_pkg::*;
#(
  parameter int unsigned Width = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nibble_serial_alu_seq_if.slave  bus
);

  localparam int unsigned Nibbles = Width / NibbleW;
  localparam int unsigned IdxW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;
  localparam int unsigned SelW    = IdxW + 2;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nibbles - 1);

  seq_state_t state_q, state_d;

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] b_q, b_d;       // B already inverted for subtraction
  logic             carry_q, carry_d;
  logic             zero_acc_q, zero_acc_d;
  logic [Width-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [SelW-1:0]    bit_sel;
  logic [NibbleW-1:0] a_nib;
  logic [NibbleW-1:0] b_nib;
  logic [NibbleW-1:0] sum_nib;
  logic               nib_cout;
  logic               nib_zero;
  logic               last_nib;

  // Nibble muxes in front of the shared adder.
  always_comb begin
    bit_sel  = {idx_q, 2'b00};
    a_nib    = a_q[bit_sel +: NibbleW];
    b_nib    = b_q[bit_sel +: NibbleW];
    last_nib = (idx_q == LastIdx);
    nib_zero = (sum_nib == '0);
  end

  nibble_serial_alu_seq_adder4 u_adder4 (
    .prop_i  (a_nib ^ b_nib),
    .gen_i   (a_nib & b_nib),
    .carry_i (carry_q),
    .sum_o   (sum_nib),
    .carry_o (nib_cout)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; abort beats completion on the final nibble.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StRun;
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (last_nib) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs, decoded straight from the state.
  always_comb begin
    bus.ready = (state_q == StIdle);
    bus.busy  = (state_q == StRun);
    bus.done  = (state_q == StDone);
  end

  // Datapath next state: operand capture, per-nibble accumulate, flag finalisation.
  always_comb begin
    idx_d      = idx_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    zero_acc_d = zero_acc_q;
    result_d   = result_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d        = bus.a;
          b_d        = op_is_sub(bus.op) ? ~bus.b : bus.b;
          carry_d    = op_init_carry(bus.op, bus.cin);
          zero_acc_d = 1'b1;
          idx_d      = '0;
          result_d   = '0;
          cout_d     = 1'b0;
          ovf_d      = 1'b0;
          zero_d     = 1'b0;
        end
      end
      StRun: begin
        if (bus.abort) begin
          idx_d    = '0;
          result_d = '0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
        end else begin
          result_d[bit_sel +: NibbleW] = sum_nib;
          carry_d    = nib_cout;
          zero_acc_d = zero_acc_q & nib_zero;
          if (last_nib) begin
            cout_d = nib_cout;
            zero_d = zero_acc_q & nib_zero;
            // Operands agree in sign but the result sign differs.
            ovf_d  = (a_q[Width-1] == b_q[Width-1]) & (sum_nib[NibbleW-1] != a_q[Width-1]);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      zero_acc_q <= zero_acc_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  // Registered results straight to the bus.
  always_comb begin
    bus.result    = result_q;
    bus.carry_out = cout_q;
    bus.overflow  = ovf_q;
    bus.zero      = zero_q;
  end

endmodule

// File: doc/nibble_serial_alu_seq.md
Name: nibble_serial_alu_seq

Overview:
- Multi-cycle add/subtract sequencer that time-shares one adder4 nibble datapath across a WIDTH-bit operation, one nibble per clock, LSB first.
- Latches operands on a start handshake and steps a nibble index, threading the carry through a register.
- Accumulates result and flags, and signals completion with a one-cycle done pulse.
- Sits between the core's execute control and the arithmetic datapath; used where area matters more than latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 8.
NIBBLES, WIDTH/4, derived; number of RUN cycles.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when ready=1
op  input  2  alu_op_t: ADD=0, ADC=1, SUB=2, SBC=3
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
cin  input  1  carry/not-borrow in for ADC/SBC, sampled on accepted start
abort  input  1  cancel an in-flight operation
ready  output  1  high in IDLE
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
result  output  WIDTH  sum/difference; valid from done until the next accepted start
carry_out  output  1  final carry (SUB/SBC: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  result == 0

Behaviour:
- Synchronous reset has priority over all inputs and acts in any state, including mid-RUN. Reset values: state=IDLE, idx=0, result=0, carry_out=0, overflow=0, zero=0, so ready=1, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE with start=1:
  - latch a into a_q.
  - latch b_eff = (op is SUB or SBC) ? ~b : b.
  - set carry_q = ADD:0, ADC:cin, SUB:1, SBC:cin.
  - clear result; set zero_acc=1; set idx=0; go to RUN.
- IDLE with start=0: hold.
- start is ignored when ready=0 (no queuing).
- RUN, each cycle, nibble i=idx:
  - prop = a_q[4i+3:4i] ^ b_eff[4i+3:4i]; gen = the same nibbles ANDed; carry_in = carry_q.
  - At the edge: result[4i+3:4i] <= sum; carry_q <= adder carry_out; zero_acc <= zero_acc & (sum==0); idx <= idx+1.
  - On the last nibble (idx==NIBBLES-1), also go to DONE instead of incrementing idx:
    - carry_out <= adder carry_out; zero <= zero_acc & (sum==0).
    - overflow <= (a_q[MSB]==b_eff[MSB]) & (sum[3]!=a_q[MSB]).
- DONE: done=1 for exactly one cycle, then unconditionally to IDLE; start in DONE is ignored.
- Latency:
  - Start sampled at edge E gives done high in the cycle after edge E+NIBBLES (9 cycles after acceptance for WIDTH=32).
  - Throughput is one operation per NIBBLES+2 cycles.
- abort=1 in RUN: next edge goes to IDLE; result, carry_out, overflow and zero are cleared to 0; no done pulse. abort is ignored in IDLE and DONE. reset_n=0 overrides a simultaneous abort.
- Outputs result, carry_out, overflow and zero are registered. They are stable in IDLE after a completed operation and are only cleared by reset, abort, or the next accepted start.
- Arithmetic wraps modulo 2^WIDTH; no saturation.

Decomposition:
- Shared package alu_pkg: alu_op_t enum (ADD/ADC/SUB/SBC), seq_state_t enum (IDLE/RUN/DONE), NIBBLE_W=4 constant.
- Single sub-module: one instance of the existing adder4, fed by nibble muxes on a_q/b_eff.
- No other hierarchy.

Test Plan:
- Reset then ADD with a=0x0000_0001, b=0xFFFF_FFFF -> done 9 cycles after start; result=0, carry_out=1, zero=1, overflow=0; busy high for 8 cycles.
- ADD with a=0x7FFF_FFFF, b=1 -> result=0x8000_0000, overflow=1, carry_out=0, zero=0.
- SUB with a=5, b=7 -> result=0xFFFF_FFFE, carry_out=0 (borrow), overflow=0. SBC with a=0x10, b=0x01, cin=0 -> result=0x0E, carry_out=1.
- Start pulsed during RUN and in DONE with different operands -> ignored; the first operation's result is unchanged. A new start in the following IDLE cycle is accepted.
- abort asserted in RUN at idx=3 -> IDLE next edge; no done; result=0, ready=1. reset_n=0 at idx=5 -> same; all outputs at reset values.
- Random ops/operands with cin, 10k ops, scoreboard -> result, carry_out, overflow and zero match a full-width reference model; done is always exactly one cycle and occurs exactly NIBBLES+1 cycles after acceptance.
